// File: rtl/move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : move_input_conditioner
// Purpose  : Turns nine raw, bouncing cell push-buttons into clean one-cycle
//            move pulses for the tic_tac_toe board. Each button bit is
//            synchronised, the whole set is debounced, and only one press is
//            accepted at a time. A full release is required before the next
//            move. Moves are suppressed while the game is locked, and a stable
//            multi-button press raises a conflict pulse instead of a move.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-low reset
//            btn_raw    - raw buttons, bit0=a .. bit8=i, asynchronous
//            lock       - game over; blocks move emission
//            a..i       - one-cycle move pulse per cell
//            move_valid - high together with any cell pulse
//            move_idx   - index 0..8 of the pulsed cell, 0 otherwise
//            conflict   - one-cycle pulse for a stable multi-button press
//            busy       - high whenever the block is not idle
// Revision : 1.0 - initial release
// ============================================================================
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn_raw,
  input  logic       lock,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       i,
  output logic       move_valid,
  output logic [3:0] move_idx,
  output logic       conflict,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_EMIT     = 3'd2,
    ST_CONFLICT = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  logic [8:0]       sync1, s;
  state_t           state, state_n;
  logic [8:0]       cand, cand_n;
  logic [CNT_W-1:0] count, count_n;
  logic [8:0]       cells;
  logic [3:0]       cand_idx;
  logic             multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = (cand & (cand - 9'd1)) != 9'd0;

  assign {i, h, g, f, e, d, c, b, a} = cells;

  // Index of the (single) set bit in the captured vector.
  always_comb begin
    cand_idx = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (cand[k]) cand_idx = 4'(k);
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    count_n = count;
    case (state)
      ST_IDLE: begin
        if (s != 9'd0) begin
          cand_n  = s;
          count_n = '0;
          state_n = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (s != cand) begin
          // Bounce or changed button set: restart capture from idle.
          state_n = ST_IDLE;
          count_n = '0;
        end else if (count == CNT_MAX) begin
          // Decision edge; the multi-press check outranks lock.
          count_n = '0;
          if (multi)     state_n = ST_CONFLICT;
          else if (lock) state_n = ST_WAIT_REL;
          else           state_n = ST_EMIT;
        end else begin
          count_n = count + CNT_W'(1);
        end
      end
      ST_EMIT, ST_CONFLICT: begin
        state_n = ST_WAIT_REL;
        count_n = '0;
      end
      ST_WAIT_REL: begin
        // Only a run of all-released cycles ends the press; anything else
        // (including extra buttons) just restarts the run.
        if (s != 9'd0) begin
          count_n = '0;
        end else if (count == CNT_MAX) begin
          state_n = ST_IDLE;
          cand_n  = 9'd0;
          count_n = '0;
        end else begin
          count_n = count + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cand_n  = 9'd0;
        count_n = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up exactly
  // with the cycle the state register spends in EMIT / CONFLICT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1      <= 9'd0;
      s          <= 9'd0;
      state      <= ST_IDLE;
      cand       <= 9'd0;
      count      <= '0;
      cells      <= 9'd0;
      move_valid <= 1'b0;
      move_idx   <= 4'd0;
      conflict   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1      <= btn_raw;
      s          <= sync1;
      state      <= state_n;
      cand       <= cand_n;
      count      <= count_n;
      cells      <= (state_n == ST_EMIT) ? cand : 9'd0;
      move_valid <= (state_n == ST_EMIT);
      move_idx   <= (state_n == ST_EMIT) ? cand_idx : 4'd0;
      conflict   <= (state_n == ST_CONFLICT);
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_input_conditioner
// Purpose  : Bench for move_input_conditioner. Directed scenarios plus a
//            random phase; every cycle the DUT outputs are compared against
//            a behavioural model of press/release runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_input_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] btn_raw = 9'd0;
  logic       lock = 1'b0;
  logic       a, b, c, d, e, f, g, h, i;
  logic       move_valid, conflict, busy;
  logic [3:0] move_idx;

  int checks = 0;
  int errors = 0;

  move_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .lock(lock),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .move_valid(move_valid), .move_idx(move_idx),
    .conflict(conflict), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // FREE: nothing held; PRESS: a captured button set is being timed;
  // HELD: the press has been judged and a full release is awaited.
  localparam int FREE = 0, PRESS = 1, HELD = 2;
  logic [8:0] m_s1 = 0, m_s2 = 0, m_cap = 0;
  int         m_mode = FREE, m_run = 0, m_zero = 0;
  bit         m_skip = 0;
  logic [8:0] m_cells = 0;
  logic       m_valid = 0, m_conf = 0, m_busy = 0;
  logic [3:0] m_idx = 0;

  task automatic model_step();
    logic [8:0] sv;
    sv = m_s2;
    m_cells = 0; m_valid = 0; m_idx = 0; m_conf = 0;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_cap = 0; m_mode = FREE;
      m_run = 0; m_zero = 0; m_skip = 0; m_busy = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    case (m_mode)
      FREE: if (sv != 0) begin m_cap = sv; m_run = 1; m_mode = PRESS; end
      PRESS: begin
        if (sv != m_cap) m_mode = FREE;
        else begin
          m_run++;
          // capture edge plus DC stable edges decides the press
          if (m_run == DC + 1) begin
            m_mode = HELD; m_zero = 0; m_skip = 0;
            if ($countones(m_cap) > 1) begin m_conf = 1; m_skip = 1; end
            else if (!lock) begin
              m_cells = m_cap; m_valid = 1; m_skip = 1;
              for (int k = 0; k < 9; k++) if (m_cap[k]) m_idx = 4'(k);
            end
          end
        end
      end
      default: begin
        if (m_skip) m_skip = 0;  // the one-cycle pulse state
        else begin
          m_zero = (sv == 0) ? m_zero + 1 : 0;
          if (m_zero == DC) begin m_mode = FREE; m_zero = 0; end
        end
      end
    endcase
    m_busy = (m_mode != FREE);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if ({i, h, g, f, e, d, c, b, a} !== m_cells || move_valid !== m_valid ||
          move_idx !== m_idx || conflict !== m_conf || busy !== m_busy) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got cells=%h valid=%b idx=%0d conf=%b busy=%b, need cells=%h valid=%b idx=%0d conf=%b busy=%b",
                 $time, {i, h, g, f, e, d, c, b, a}, move_valid, move_idx, conflict, busy,
                 m_cells, m_valid, m_idx, m_conf, m_busy);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  // Run n cycles, counting pulses and remembering where the first one fell.
  task automatic run(input int n, output int pulses, output int first_k,
                     output int last_idx, output int confs, output logic [8:0] cells_or);
    pulses = 0; first_k = -1; last_idx = -1; confs = 0; cells_or = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cells_or |= {i, h, g, f, e, d, c, b, a};
      if (conflict) confs++;
      if (move_valid) begin
        pulses++;
        last_idx = move_idx;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  task automatic drive(input logic [8:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  int np, fk, li, nc;
  logic [8:0] co;

  initial begin
    // Reset then idle
    reset = 1'b0; btn_raw = 0; lock = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    run(50, np, fk, li, nc, co);
    chk("idle_pulses", np, 0);
    chk("idle_busy", int'(busy), 0);

    // Clean press on a
    drive(9'h001);
    run(20, np, fk, li, nc, co);
    chk("clean_pulses", np, 1);
    chk("clean_latency", fk, 6);
    chk("clean_idx", li, 0);
    chk("clean_cells", int'(co), 1);
    drive(9'h000);
    run(3, np, fk, li, nc, co);
    chk("clean_busy_hold", int'(busy), 1);
    run(3, np, fk, li, nc, co);
    chk("clean_busy_release", int'(busy), 0);

    // Bounce on e, then stable
    for (int r = 0; r < 4; r++) begin
      drive((r % 2 == 0) ? 9'h010 : 9'h000);
      run(1, np, fk, li, nc, co);
      chk("bounce_quiet", np, 0);
    end
    drive(9'h010);
    run(10, np, fk, li, nc, co);
    chk("bounce_pulses", np, 1);
    chk("bounce_latency", fk, DC + 2);
    chk("bounce_idx", li, 4);
    drive(9'h000);
    run(10, np, fk, li, nc, co);

    // Multi-press, then i
    drive(9'h003);
    run(10, np, fk, li, nc, co);
    chk("multi_conflicts", nc, 1);
    chk("multi_pulses", np, 0);
    drive(9'h000);
    run(10, np, fk, li, nc, co);
    drive(9'h100);
    run(10, np, fk, li, nc, co);
    chk("i_pulses", np, 1);
    chk("i_idx", li, 8);
    drive(9'h000);
    run(10, np, fk, li, nc, co);

    // Lock
    @(negedge clk); lock = 1'b1;
    drive(9'h002);
    run(10, np, fk, li, nc, co);
    chk("lock_pulses", np, 0);
    chk("lock_busy", int'(busy), 1);
    drive(9'h000);
    run(10, np, fk, li, nc, co);
    chk("lock_busy_after", int'(busy), 0);
    @(negedge clk); lock = 1'b0;
    drive(9'h002);
    run(10, np, fk, li, nc, co);
    chk("unlock_pulses", np, 1);
    chk("unlock_idx", li, 1);
    drive(9'h000);
    run(10, np, fk, li, nc, co);

    // Reset mid-debounce with c held
    drive(9'h004);
    run(4, np, fk, li, nc, co);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(move_valid), 0);
    @(negedge clk); reset = 1'b1;
    run(12, np, fk, li, nc, co);
    chk("c_after_reset", np, 1);
    chk("c_idx", li, 2);
    // Overlap: add d while c still down
    drive(9'h00C);
    run(10, np, fk, li, nc, co);
    chk("overlap_pulses", np, 0);
    drive(9'h008);
    run(10, np, fk, li, nc, co);
    chk("partial_release_pulses", np, 0);
    drive(9'h000);
    run(10, np, fk, li, nc, co);
    drive(9'h008);
    run(10, np, fk, li, nc, co);
    chk("d_pulses", np, 1);
    chk("d_idx", li, 3);
    drive(9'h000);
    run(10, np, fk, li, nc, co);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 99) < 3) lock = ~lock;
      if ($urandom_range(0, 99) < 9) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 40)      btn_raw = 9'h000;
        else if (r < 85) btn_raw = 9'(1 << $urandom_range(0, 8));
        else             btn_raw = 9'($urandom_range(0, 511));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
